// File: rtl/snake_matrix_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snake_matrix_scan: 8x8 row-scanned LED driver with frame snapshot and food blink. Rev 1.0
// ---------------------------------------------------------------------------
module snake_matrix_scan #(
  parameter int CNT_ROW     = 50_000,
  parameter int BLANK_CYC   = 500,
  parameter int BLINK_SCANS = 62
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] snake_body,
  input  logic [2:0]  snake_len,
  input  logic [5:0]  score_position,
  input  logic        display_en,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_start
);

  localparam int DW = (CNT_ROW > 1) ? $clog2(CNT_ROW) : 1;
  localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [DW-1:0] c_dwell_last = DW'(CNT_ROW - 1);
  localparam logic [DW-1:0] c_blank      = DW'(BLANK_CYC);
  localparam logic [SW-1:0] c_scan_last  = SW'(BLINK_SCANS - 1);
  localparam logic [23:0]   c_body_rst   = {4{6'd15}};

  logic [DW-1:0] r_dwell;
  logic [2:0]    r_row;
  logic [SW-1:0] r_scan;
  logic          r_food_on;
  logic [23:0]   r_snap_body;
  logic [2:0]    r_snap_len;
  logic [5:0]    r_snap_food;

  logic          w_dwell_wrap;
  logic          w_frame_wrap;
  logic [2:0]    w_len_clamped;
  logic [3:0]    w_seg_act;
  logic [5:0]    w_seg [4];
  logic [7:0]    w_pattern;

  assign w_dwell_wrap = (r_dwell == c_dwell_last);
  assign w_frame_wrap = w_dwell_wrap && (r_row == 3'd7);

  always_comb begin
    w_len_clamped = snake_len;
    if (snake_len == 3'd0) begin
      w_len_clamped = 3'd1;
    end else if (snake_len > 3'd4) begin
      w_len_clamped = 3'd4;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dwell <= '0;
      r_row   <= 3'd0;
    end else if (w_dwell_wrap) begin
      r_dwell <= '0;
      r_row   <= r_row + 3'd1;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Game-core inputs are sampled only at the frame boundary to avoid tearing.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_snap_body <= c_body_rst;
      r_snap_len  <= 3'd1;
      r_snap_food <= 6'd0;
    end else if (w_frame_wrap) begin
      r_snap_body <= snake_body;
      r_snap_len  <= w_len_clamped;
      r_snap_food <= score_position;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scan    <= '0;
      r_food_on <= 1'b1;
    end else if (w_frame_wrap) begin
      if (r_scan == c_scan_last) begin
        r_scan    <= '0;
        r_food_on <= ~r_food_on;
      end else begin
        r_scan <= r_scan + SW'(1);
      end
    end
  end

  assign w_seg[0]  = r_snap_body[23:18];
  assign w_seg[1]  = r_snap_body[17:12];
  assign w_seg[2]  = r_snap_body[11:6];
  assign w_seg[3]  = r_snap_body[5:0];
  assign w_seg_act = {r_snap_len == 3'd4, r_snap_len >= 3'd3, r_snap_len >= 3'd2, 1'b1};

  always_comb begin
    w_pattern = 8'h00;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (w_seg_act[k] && (w_seg[k] == {r_row, 3'(c)})) begin
          w_pattern[c] = 1'b1;
        end
      end
      if (r_food_on && (r_snap_food == {r_row, 3'(c)})) begin
        w_pattern[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_sel     <= 8'h01;
      col_data    <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_frame_wrap;
      row_sel     <= display_en ? (8'h01 << r_row) : 8'h00;
      col_data    <= (display_en && (r_dwell >= c_blank)) ? w_pattern : 8'h00;
    end
  end

endmodule
`default_nettype wire
